// File: rtl/controle_saida_pkg.sv
// controle_saida_pkg: shared state enums and seven-segment constants for the Pratica03 controllers
package controle_saida_pkg;
  typedef enum logic [2:0] {
    OUT_IDLE    = 3'd0,
    OUT_SHOW_HI = 3'd1,
    OUT_HOLD_HI = 3'd2,
    OUT_SHOW_LO = 3'd3,
    OUT_HOLD_LO = 3'd4,
    OUT_DONE    = 3'd5
  } controle_saida_t;
  typedef enum logic [1:0] {
    IN_IDLE    = 2'd0,
    IN_LOAD_A  = 2'd1,
    IN_LOAD_B  = 2'd2,
    IN_COMPUTE = 2'd3
  } controle_entrada_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
endpackage

// File: rtl/controle_saida_hex7seg.sv
// hex7seg: combinational hex digit to active-low seven-segment decoder, order {g,f,e,d,c,b,a}
module hex7seg (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);
  always_comb begin
    case (nibble_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      default: seg_o = 7'h0E;
    endcase
  end
endmodule

// File: rtl/controle_saida.sv
// controle_saida: latches an 8-bit result and steps it out high/low nibble on a 7-seg digit per button press
module controle_saida
  import controle_saida_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [7:0] result_i,
  input  logic       next_i,
  output logic [3:0] nibble_o,
  output logic [6:0] seg_o,
  output logic       sel_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [2:0] fsm_state_o
);
  controle_saida_t        state_q, state_d;
  logic [7:0]             res_q, res_d;
  logic                   valid_q, valid_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   next_s, accept, hi;
  logic [6:0]             seg_dec;

  assign next_s = sync_q[SYNC_STAGES-1];
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], next_i};
    valid_d = valid_i;
    accept  = valid_i & ~valid_q & (state_q == OUT_IDLE);
    res_d   = accept ? result_i : res_q;
    case (state_q)
      OUT_IDLE:    state_d = accept ? OUT_SHOW_HI : OUT_IDLE;
      OUT_SHOW_HI: state_d = next_s ? OUT_SHOW_HI : OUT_HOLD_HI;
      OUT_HOLD_HI: state_d = next_s ? OUT_SHOW_LO : OUT_HOLD_HI;
      OUT_SHOW_LO: state_d = next_s ? OUT_SHOW_LO : OUT_HOLD_LO;
      OUT_HOLD_LO: state_d = next_s ? OUT_DONE : OUT_HOLD_LO;
      default:     state_d = OUT_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= OUT_IDLE;
      res_q   <= '0;
      valid_q <= 1'b0;
      sync_q  <= '1;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      sync_q  <= sync_d;
    end
  end

  hex7seg u_hex (
    .nibble_i(nibble_o),
    .seg_o   (seg_dec)
  );

  assign hi          = (state_q == OUT_SHOW_HI) || (state_q == OUT_HOLD_HI);
  assign nibble_o    = (state_q == OUT_IDLE) ? 4'h0 : hi ? res_q[7:4] : res_q[3:0];
  assign seg_o       = (state_q == OUT_IDLE) ? SEG_BLANK : seg_dec;
  assign sel_o       = hi;
  assign busy_o      = state_q != OUT_IDLE;
  assign done_o      = state_q == OUT_DONE;
  assign fsm_state_o = state_q;
endmodule

// File: tb/tb_controle_saida.sv
// tb_controle_saida: table-driven check of the nibble display sequencer plus reset/idle corner sequences
module tb_controle_saida;
  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       valid_i = 1'b0;
  logic [7:0] result_i = 8'h00;
  logic       next_i = 1'b1;
  logic [3:0] nibble_o;
  logic [6:0] seg_o;
  logic       sel_o, busy_o, done_o;
  logic [2:0] fsm_state_o;

  controle_saida #(.SYNC_STAGES(2)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .result_i   (result_i),
    .next_i     (next_i),
    .nibble_o   (nibble_o),
    .seg_o      (seg_o),
    .sel_o      (sel_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .fsm_state_o(fsm_state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] r;
    logic       n;
    logic [2:0] st;
    logic [3:0] nib;
    logic       dn;
  } vec_t;

  vec_t tbl[$];
  int   passed = 0;
  int   total = 0;
  logic [6:0] seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // packed view: {state, nibble, seg, sel, busy, done}
  function automatic logic [16:0] exp_of(input logic [2:0] st, input logic [3:0] nib, input logic dn);
    logic [6:0] seg;
    seg = (st == 3'd0) ? 7'h7F : seg_lut[nib];
    return {st, nib, seg, (st == 3'd1) || (st == 3'd2), st != 3'd0, dn};
  endfunction

  function automatic logic [16:0] act();
    return {fsm_state_o, nibble_o, seg_o, sel_o, busy_o, done_o};
  endfunction

  task automatic check(input string name, input logic [16:0] a, input logic [16:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got {st,nib,seg,sel,busy,done}=%h expected %h", name, a, e);
  endtask

  task automatic add(input logic v, input logic [7:0] r, input logic n,
                     input logic [2:0] st, input logic [3:0] nib, input logic dn);
    vec_t x;
    x.v = v; x.r = r; x.n = n; x.st = st; x.nib = nib; x.dn = dn;
    tbl.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 0xA7 with a one-cycle valid pulse
    add(1, 8'hA7, 1, 1, 4'hA, 0); add(0, 8'hA7, 0, 1, 4'hA, 0); add(0, 8'hA7, 0, 1, 4'hA, 0);
    add(0, 8'hA7, 1, 2, 4'hA, 0); add(0, 8'hA7, 1, 2, 4'hA, 0); add(0, 8'hA7, 1, 3, 4'h7, 0);
    add(0, 8'hA7, 0, 3, 4'h7, 0); add(0, 8'hA7, 0, 3, 4'h7, 0); add(0, 8'hA7, 1, 4, 4'h7, 0);
    add(0, 8'hA7, 1, 4, 4'h7, 0); add(0, 8'hA7, 1, 5, 4'h7, 1); add(0, 8'hA7, 1, 0, 4'h0, 0);
    // 0x35 with valid held high across DONE -> IDLE, then 0xF0 after a drop
    add(1, 8'h35, 1, 1, 4'h3, 0); add(1, 8'h35, 0, 1, 4'h3, 0); add(1, 8'h35, 0, 1, 4'h3, 0);
    add(1, 8'h35, 1, 2, 4'h3, 0); add(1, 8'h35, 1, 2, 4'h3, 0); add(1, 8'h35, 1, 3, 4'h5, 0);
    add(1, 8'h35, 0, 3, 4'h5, 0); add(1, 8'h35, 0, 3, 4'h5, 0); add(1, 8'h35, 1, 4, 4'h5, 0);
    add(1, 8'h35, 1, 4, 4'h5, 0); add(1, 8'h35, 1, 5, 4'h5, 1); add(1, 8'h35, 1, 0, 4'h0, 0);
    add(1, 8'h35, 1, 0, 4'h0, 0); add(0, 8'hF0, 1, 0, 4'h0, 0); add(1, 8'hF0, 1, 1, 4'hF, 0);
    add(0, 8'hF0, 0, 1, 4'hF, 0); add(0, 8'hF0, 0, 1, 4'hF, 0); add(0, 8'hF0, 1, 2, 4'hF, 0);
    add(0, 8'hF0, 1, 2, 4'hF, 0); add(0, 8'hF0, 1, 3, 4'h0, 0); add(0, 8'hF0, 0, 3, 4'h0, 0);
    add(0, 8'hF0, 0, 3, 4'h0, 0); add(0, 8'hF0, 1, 4, 4'h0, 0); add(0, 8'hF0, 1, 4, 4'h0, 0);
    add(0, 8'hF0, 1, 5, 4'h0, 1); add(0, 8'hF0, 1, 0, 4'h0, 0);
    // 0x6C, then a second valid pulse with 0x11 while showing must be ignored; stop in HOLD_LO
    add(1, 8'h6C, 1, 1, 4'h6, 0); add(0, 8'h11, 1, 1, 4'h6, 0); add(1, 8'h11, 1, 1, 4'h6, 0);
    add(0, 8'h11, 1, 1, 4'h6, 0); add(0, 8'h11, 0, 1, 4'h6, 0); add(0, 8'h11, 0, 1, 4'h6, 0);
    add(0, 8'h11, 1, 2, 4'h6, 0); add(0, 8'h11, 1, 2, 4'h6, 0); add(0, 8'h11, 1, 3, 4'hC, 0);
    add(0, 8'h11, 0, 3, 4'hC, 0); add(0, 8'h11, 0, 3, 4'hC, 0); add(0, 8'h11, 1, 4, 4'hC, 0);

    #1;
    check("reset_held", act(), exp_of(0, 0, 0));
    tick(); tick();
    rst_i = 1'b1;
    tick();
    check("idle_after_release", act(), exp_of(0, 0, 0));

    foreach (tbl[i]) begin
      valid_i  = tbl[i].v;
      result_i = tbl[i].r;
      next_i   = tbl[i].n;
      tick();
      check($sformatf("row%0d", i), act(), exp_of(tbl[i].st, tbl[i].nib, tbl[i].dn));
    end

    // asynchronous reset in HOLD_LO: blank at once, DONE never reached
    rst_i = 1'b0;
    #1;
    check("rst_async_hold_lo", act(), exp_of(0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rst_held%0d", k), act(), exp_of(0, 0, 0));
    end
    valid_i = 1'b0;
    next_i  = 1'b1;
    rst_i   = 1'b1;
    // button activity in IDLE is ignored
    for (int k = 0; k < 6; k++) begin
      next_i = (k < 3) ? 1'b0 : 1'b1;
      tick();
      check($sformatf("idle_button%0d", k), act(), exp_of(0, 0, 0));
    end
    valid_i  = 1'b1;
    result_i = 8'h5A;
    tick();
    check("post_rst_5A", act(), exp_of(1, 4'h5, 0));
    valid_i = 1'b0;
    tick();
    check("post_rst_5A_hold", act(), exp_of(1, 4'h5, 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
